// File: rtl/portin.sv
// Serial-to-parallel port receiver: assembles active-low framed/validated
// LSB-first bit streams into WIDTH-bit words and pushes them to a FIFO.
module portin #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             framei_n,
  input  logic             validi_n,
  input  logic             din,
  input  logic             full,
  output logic [WIDTH-1:0] payload,
  output logic             push,
  output logic             err,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [WIDTH-1:0] payload_q, payload_d;
  logic             pend_q,    pend_d;
  logic             err_q,     err_d;
  logic             ovf_q,     ovf_d;

  logic             bit_in;
  logic             word_done;
  logic [WIDTH-1:0] word;

  assign bit_in = ~framei_n & ~validi_n;
  // shift_q is zero above count_q, so OR-ing places din at position count_q.
  assign word   = shift_q | ({{(WIDTH-1){1'b0}}, din} << count_q);
  assign push   = pend_q & ~full;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    err_d     = 1'b0;
    word_done = 1'b0;
    case (state_q)
      ST_SYNC: begin
        if (framei_n) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!framei_n) begin
          state_d = ST_RECV;
          if (bit_in) begin
            shift_d = word;
            count_d = CNT_W'(1);
          end
        end
      end
      ST_RECV: begin
        if (framei_n) begin
          err_d   = 1'b1;
          shift_d = '0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (bit_in) begin
          if (count_q == LAST_BIT) begin
            word_done = 1'b1;
            shift_d   = '0;
            count_d   = '0;
            state_d   = ST_TAIL;
          end else begin
            shift_d = word;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_TAIL: begin
        if (framei_n)    state_d = ST_IDLE;
        else if (bit_in) err_d   = 1'b1;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  // A completed word may replace the held one only if that word leaves this cycle.
  always_comb begin
    payload_d = payload_q;
    pend_d    = pend_q;
    ovf_d     = 1'b0;
    if (push) pend_d = 1'b0;
    if (word_done) begin
      if (!pend_q || push) begin
        payload_d = word;
        pend_d    = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_SYNC;
      shift_q   <= '0;
      count_q   <= '0;
      payload_q <= '0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      payload_q <= payload_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign payload = payload_q;
  assign err     = err_q;
  assign ovf     = ovf_q;

endmodule
